// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg -- bus-wide constants shared by AXI-Lite blocks.
//   AXI_ADDR_W : byte address width
//   AXI_DATA_W : data width
//   AXI_STRB_W : byte-enable width (one bit per data byte)
//   strb_to_mask() expands a byte-enable vector into a per-bit data mask.
package axi_lite_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;

  // Expand each strobe bit over its 8 data bits.
  function automatic logic [AXI_DATA_W-1:0] strb_to_mask(input logic [AXI_STRB_W-1:0] strb);
    logic [AXI_DATA_W-1:0] mask;
    mask = {AXI_DATA_W{1'b0}};
    for (int i = 0; i < AXI_STRB_W; i++) begin
      mask[8*i +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/axi_lite_mem_ram.sv
// axi_lite_mem_ram -- word storage for axi_lite_mem.
//   clock   : rising-edge clock
//   wr_en   : commit a write this edge
//   wr_idx  : word index written
//   wr_data : write data
//   wr_strb : byte enables; only enabled bytes change
//   rd_en   : capture a read this edge
//   rd_idx  : word index read
//   rd_data : registered read data, held until the next rd_en
// The read port samples the array before a same-edge write lands, so a
// read and a write to the same word return the old contents. No reset.
module axi_lite_mem_ram
  import axi_lite_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [AXI_DATA_W-1:0] wr_data,
  input  logic [AXI_STRB_W-1:0] wr_strb,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [AXI_DATA_W-1:0] rd_data
);

  logic [AXI_DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [AXI_DATA_W-1:0] rd_data_q;
  logic [AXI_DATA_W-1:0] wr_mask;

  assign wr_mask = strb_to_mask(wr_strb);

  // Byte-enabled write port: merge enabled bytes into the stored word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    end
  end

  // Synchronous read port; output holds while rd_en is low.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_idx];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_mem.sv
// axi_lite_mem -- AXI4-Lite slave backed by a DEPTH_WORDS x 32-bit memory.
//   clock                : rising-edge clock
//   reset                : asynchronous, active-low
//   MEM_AW* (VALID/READY/ADDR)        : write address channel
//   MEM_W*  (VALID/READY/DATA/STRB)   : write data channel
//   MEM_B*  (VALID/READY)             : write response channel
//   MEM_AR* (VALID/READY/ADDR)        : read address channel
//   MEM_R*  (VALID/READY/DATA)        : read data channel
// Write path: one AW slot and one W slot fill independently; when both are
// full and the response slot is free (or draining this edge) the write
// commits. Read path: one-deep, independent of the write path.
// Addresses use bits [IDX_W+1:2] only, so they wrap modulo DEPTH_WORDS*4.
module axi_lite_mem
  import axi_lite_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  MEM_AWVALID,
  output logic                  MEM_AWREADY,
  input  logic [AXI_ADDR_W-1:0] MEM_AWADDR,
  input  logic                  MEM_WVALID,
  output logic                  MEM_WREADY,
  input  logic [AXI_DATA_W-1:0] MEM_WDATA,
  input  logic [AXI_STRB_W-1:0] MEM_WSTRB,
  output logic                  MEM_BVALID,
  input  logic                  MEM_BREADY,
  input  logic                  MEM_ARVALID,
  output logic                  MEM_ARREADY,
  input  logic [AXI_ADDR_W-1:0] MEM_ARADDR,
  output logic                  MEM_RVALID,
  input  logic                  MEM_RREADY,
  output logic [AXI_DATA_W-1:0] MEM_RDATA
);

  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [AXI_DATA_W-1:0] w_data_q, w_data_d;
  logic [AXI_STRB_W-1:0] w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rd_loaded_q, rd_loaded_d;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  arready;
  logic [AXI_DATA_W-1:0] ram_rd_data;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{MEM_AWADDR[AXI_ADDR_W-1:IDX_W+2], MEM_AWADDR[1:0],
                              MEM_ARADDR[AXI_ADDR_W-1:IDX_W+2], MEM_ARADDR[1:0]};

  assign aw_hs   = MEM_AWVALID && !aw_full_q;
  assign w_hs    = MEM_WVALID && !w_full_q;
  // A pending response draining this edge frees the slot for a new commit.
  assign commit  = aw_full_q && w_full_q && (!bvalid_q || MEM_BREADY);
  assign arready = !rvalid_q || MEM_RREADY;
  assign ar_hs   = MEM_ARVALID && arready;

  // Next-state logic for the write slots, response and read handshake.
  always_comb begin
    aw_full_d   = aw_full_q;
    aw_idx_d    = aw_idx_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    rd_loaded_d = rd_loaded_q;

    // Slots cannot accept while full, so a handshake never coincides with commit.
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_d = 1'b1;
        aw_idx_d  = MEM_AWADDR[IDX_W+1:2];
      end else begin
        aw_full_d = aw_full_q;
      end
      if (w_hs) begin
        w_full_d = 1'b1;
        w_data_d = MEM_WDATA;
        w_strb_d = MEM_WSTRB;
      end else begin
        w_full_d = w_full_q;
      end
    end

    if (commit) begin
      bvalid_d = 1'b1;
    end else if (MEM_BREADY) begin
      bvalid_d = 1'b0;
    end else begin
      bvalid_d = bvalid_q;
    end

    if (ar_hs) begin
      rvalid_d    = 1'b1;
      rd_loaded_d = 1'b1;
    end else if (MEM_RREADY) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // Control state registers; reset drops every held entry and response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aw_full_q   <= 1'b0;
      aw_idx_q    <= {IDX_W{1'b0}};
      w_full_q    <= 1'b0;
      w_data_q    <= {AXI_DATA_W{1'b0}};
      w_strb_q    <= {AXI_STRB_W{1'b0}};
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rd_loaded_q <= 1'b0;
    end else begin
      aw_full_q   <= aw_full_d;
      aw_idx_q    <= aw_idx_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rd_loaded_q <= rd_loaded_d;
    end
  end

  axi_lite_mem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (commit),
    .wr_idx  (aw_idx_q),
    .wr_data (w_data_q),
    .wr_strb (w_strb_q),
    .rd_en   (ar_hs),
    .rd_idx  (MEM_ARADDR[IDX_W+1:2]),
    .rd_data (ram_rd_data)
  );

  assign MEM_AWREADY = !aw_full_q;
  assign MEM_WREADY  = !w_full_q;
  assign MEM_BVALID  = bvalid_q;
  assign MEM_ARREADY = arready;
  assign MEM_RVALID  = rvalid_q;
  // The unreset RAM read register is masked to zero until the first read.
  assign MEM_RDATA   = ram_rd_data & {AXI_DATA_W{rd_loaded_q}};

endmodule

// File: tb/tb_axi_lite_mem.sv
// tb_axi_lite_mem -- directed self-checking bench for axi_lite_mem.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_axi_lite_mem;

  logic        clock;
  logic        reset;
  logic        MEM_AWVALID;
  logic        MEM_AWREADY;
  logic [31:0] MEM_AWADDR;
  logic        MEM_WVALID;
  logic        MEM_WREADY;
  logic [31:0] MEM_WDATA;
  logic [3:0]  MEM_WSTRB;
  logic        MEM_BVALID;
  logic        MEM_BREADY;
  logic        MEM_ARVALID;
  logic        MEM_ARREADY;
  logic [31:0] MEM_ARADDR;
  logic        MEM_RVALID;
  logic        MEM_RREADY;
  logic [31:0] MEM_RDATA;

  int checks = 0;
  int errors = 0;

  axi_lite_mem #(.DEPTH_WORDS(256)) dut (
    .clock       (clock),
    .reset       (reset),
    .MEM_AWVALID (MEM_AWVALID),
    .MEM_AWREADY (MEM_AWREADY),
    .MEM_AWADDR  (MEM_AWADDR),
    .MEM_WVALID  (MEM_WVALID),
    .MEM_WREADY  (MEM_WREADY),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_WSTRB   (MEM_WSTRB),
    .MEM_BVALID  (MEM_BVALID),
    .MEM_BREADY  (MEM_BREADY),
    .MEM_ARVALID (MEM_ARVALID),
    .MEM_ARREADY (MEM_ARREADY),
    .MEM_ARADDR  (MEM_ARADDR),
    .MEM_RVALID  (MEM_RVALID),
    .MEM_RREADY  (MEM_RREADY),
    .MEM_RDATA   (MEM_RDATA)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Full write with BREADY high; waits (bounded) for the response.
  task automatic write_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge clock);
    MEM_AWVALID = 1'b1; MEM_AWADDR = addr;
    MEM_WVALID  = 1'b1; MEM_WDATA  = data; MEM_WSTRB = strb;
    MEM_BREADY  = 1'b1;
    @(negedge clock);
    MEM_AWVALID = 1'b0; MEM_WVALID = 1'b0;
    n = 0;
    while (!MEM_BVALID && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("wr_bvalid_seen", {31'd0, MEM_BVALID}, 32'd1);
    @(negedge clock);
    MEM_BREADY = 1'b0;
  endtask

  // Full read; waits (bounded) for RVALID and returns RDATA.
  task automatic read_word(input logic [31:0] addr, output logic [31:0] data);
    int n;
    @(negedge clock);
    MEM_ARVALID = 1'b1; MEM_ARADDR = addr; MEM_RREADY = 1'b0;
    @(negedge clock);
    MEM_ARVALID = 1'b0;
    n = 0;
    while (!MEM_RVALID && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("rd_rvalid_seen", {31'd0, MEM_RVALID}, 32'd1);
    data = MEM_RDATA;
    MEM_RREADY = 1'b1;
    @(negedge clock);
    MEM_RREADY = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    reset = 1'b0;
    MEM_AWVALID = 1'b0; MEM_AWADDR = 32'd0;
    MEM_WVALID  = 1'b0; MEM_WDATA  = 32'd0; MEM_WSTRB = 4'd0;
    MEM_BREADY  = 1'b0;
    MEM_ARVALID = 1'b0; MEM_ARADDR = 32'd0;
    MEM_RREADY  = 1'b0;

    // Reset state
    #1;
    chk("rst_bvalid",  {31'd0, MEM_BVALID},  32'd0);
    chk("rst_rvalid",  {31'd0, MEM_RVALID},  32'd0);
    chk("rst_awready", {31'd0, MEM_AWREADY}, 32'd1);
    chk("rst_wready",  {31'd0, MEM_WREADY},  32'd1);
    chk("rst_arready", {31'd0, MEM_ARREADY}, 32'd1);
    chk("rst_rdata",   MEM_RDATA,            32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Test 1: simultaneous AW/W, BVALID two cycles after handshake, then read
    @(negedge clock);
    MEM_AWVALID = 1'b1; MEM_AWADDR = 32'h10;
    MEM_WVALID  = 1'b1; MEM_WDATA  = 32'hDEADBEEF; MEM_WSTRB = 4'hF;
    @(negedge clock);
    MEM_AWVALID = 1'b0; MEM_WVALID = 1'b0;
    chk("t1_awready_held", {31'd0, MEM_AWREADY}, 32'd0);
    chk("t1_wready_held",  {31'd0, MEM_WREADY},  32'd0);
    chk("t1_bvalid_early", {31'd0, MEM_BVALID},  32'd0);
    @(negedge clock);
    chk("t1_bvalid",       {31'd0, MEM_BVALID},  32'd1);
    chk("t1_awready_free", {31'd0, MEM_AWREADY}, 32'd1);
    MEM_BREADY = 1'b1;
    @(negedge clock);
    chk("t1_bvalid_clr",   {31'd0, MEM_BVALID},  32'd0);
    MEM_BREADY = 1'b0;
    MEM_ARVALID = 1'b1; MEM_ARADDR = 32'h10;
    @(negedge clock);
    MEM_ARVALID = 1'b0;
    chk("t1_rvalid",       {31'd0, MEM_RVALID},  32'd1);
    chk("t1_rdata",        MEM_RDATA,            32'hDEADBEEF);
    chk("t1_arready_low",  {31'd0, MEM_ARREADY}, 32'd0);
    MEM_RREADY = 1'b1;
    @(negedge clock);
    chk("t1_rvalid_clr",   {31'd0, MEM_RVALID},  32'd0);
    MEM_RREADY = 1'b0;

    // Test 2: W three cycles before AW, strobe on byte 0 only
    @(negedge clock);
    MEM_WVALID = 1'b1; MEM_WDATA = 32'h000000AA; MEM_WSTRB = 4'h1;
    @(negedge clock);
    MEM_WVALID = 1'b0;
    chk("t2_wready_low1", {31'd0, MEM_WREADY}, 32'd0);
    @(negedge clock);
    chk("t2_wready_low2", {31'd0, MEM_WREADY}, 32'd0);
    @(negedge clock);
    MEM_AWVALID = 1'b1; MEM_AWADDR = 32'h10; MEM_BREADY = 1'b1;
    @(negedge clock);
    MEM_AWVALID = 1'b0;
    chk("t2_wready_low3", {31'd0, MEM_WREADY}, 32'd0);
    chk("t2_bvalid_early", {31'd0, MEM_BVALID}, 32'd0);
    @(negedge clock);
    chk("t2_wready_free", {31'd0, MEM_WREADY}, 32'd1);
    chk("t2_bvalid",      {31'd0, MEM_BVALID}, 32'd1);
    @(negedge clock);
    chk("t2_bvalid_clr",  {31'd0, MEM_BVALID}, 32'd0);
    MEM_BREADY = 1'b0;
    read_word(32'h10, rd);
    chk("t2_rdata", rd, 32'hDEADBEAA);

    // Zero strobe: response but no change
    write_word(32'h10, 32'hFFFFFFFF, 4'h0);
    read_word(32'h10, rd);
    chk("strb0_rdata", rd, 32'hDEADBEAA);

    // Test 3: address wrap (0x400 -> word 0)
    write_word(32'h400, 32'h11223344, 4'hF);
    read_word(32'h0, rd);
    chk("t3_wrap_rdata", rd, 32'h11223344);

    // Test 4: backpressure on B and R
    @(negedge clock);
    MEM_AWVALID = 1'b1; MEM_AWADDR = 32'h20;
    MEM_WVALID  = 1'b1; MEM_WDATA  = 32'hCAFEF00D; MEM_WSTRB = 4'hF;
    MEM_ARVALID = 1'b1; MEM_ARADDR = 32'h0;
    MEM_BREADY  = 1'b0; MEM_RREADY = 1'b0;
    @(negedge clock);
    MEM_AWVALID = 1'b0; MEM_WVALID = 1'b0; MEM_ARVALID = 1'b0;
    chk("t4_rvalid",  {31'd0, MEM_RVALID},  32'd1);
    chk("t4_rdata",   MEM_RDATA,            32'h11223344);
    chk("t4_arready", {31'd0, MEM_ARREADY}, 32'd0);
    @(negedge clock);
    chk("t4_bvalid",  {31'd0, MEM_BVALID},  32'd1);
    MEM_AWVALID = 1'b1; MEM_AWADDR = 32'h24;
    MEM_WVALID  = 1'b1; MEM_WDATA  = 32'h01020304; MEM_WSTRB = 4'hF;
    @(negedge clock);
    MEM_AWVALID = 1'b0; MEM_WVALID = 1'b0;
    chk("t4_awready_full", {31'd0, MEM_AWREADY}, 32'd0);
    chk("t4_wready_full",  {31'd0, MEM_WREADY},  32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("t4_hold_bvalid",  {31'd0, MEM_BVALID},  32'd1);
      chk("t4_hold_rvalid",  {31'd0, MEM_RVALID},  32'd1);
      chk("t4_hold_rdata",   MEM_RDATA,            32'h11223344);
      chk("t4_hold_arready", {31'd0, MEM_ARREADY}, 32'd0);
      chk("t4_hold_awready", {31'd0, MEM_AWREADY}, 32'd0);
      chk("t4_hold_wready",  {31'd0, MEM_WREADY},  32'd0);
    end
    MEM_BREADY = 1'b1;
    @(negedge clock);
    chk("t4_b2b_bvalid",  {31'd0, MEM_BVALID},  32'd1);
    chk("t4_b2b_awready", {31'd0, MEM_AWREADY}, 32'd1);
    chk("t4_b2b_wready",  {31'd0, MEM_WREADY},  32'd1);
    @(negedge clock);
    chk("t4_bvalid_clr",  {31'd0, MEM_BVALID},  32'd0);
    MEM_BREADY = 1'b0;
    MEM_RREADY = 1'b1;
    @(negedge clock);
    chk("t4_rvalid_clr",  {31'd0, MEM_RVALID},  32'd0);
    MEM_RREADY = 1'b0;
    read_word(32'h24, rd);
    chk("t4_rd_24", rd, 32'h01020304);
    read_word(32'h20, rd);
    chk("t4_rd_20", rd, 32'hCAFEF00D);

    // Test 5: read-before-write at the same edge
    write_word(32'h30, 32'h12345678, 4'hF);
    @(negedge clock);
    MEM_AWVALID = 1'b1; MEM_AWADDR = 32'h30;
    MEM_WVALID  = 1'b1; MEM_WDATA  = 32'h00000055; MEM_WSTRB = 4'hF;
    MEM_BREADY  = 1'b1;
    @(negedge clock);
    MEM_AWVALID = 1'b0; MEM_WVALID = 1'b0;
    MEM_ARVALID = 1'b1; MEM_ARADDR = 32'h30; MEM_RREADY = 1'b0;
    @(negedge clock);
    MEM_ARVALID = 1'b0;
    chk("t5_bvalid", {31'd0, MEM_BVALID}, 32'd1);
    chk("t5_rvalid", {31'd0, MEM_RVALID}, 32'd1);
    chk("t5_old_data", MEM_RDATA, 32'h12345678);
    MEM_RREADY = 1'b1;
    @(negedge clock);
    MEM_RREADY = 1'b0; MEM_BREADY = 1'b0;
    read_word(32'h30, rd);
    chk("t5_new_data", rd, 32'h00000055);

    // Test 6: reset with held AW/W entries and a pending response
    write_word(32'h40, 32'hA5A5A5A5, 4'hF);
    @(negedge clock);
    MEM_AWVALID = 1'b1; MEM_AWADDR = 32'h44;
    MEM_WVALID  = 1'b1; MEM_WDATA  = 32'h11111111; MEM_WSTRB = 4'hF;
    MEM_BREADY  = 1'b0;
    @(negedge clock);
    MEM_AWVALID = 1'b0; MEM_WVALID = 1'b0;
    @(negedge clock);
    chk("t6_bvalid_pend", {31'd0, MEM_BVALID}, 32'd1);
    MEM_AWVALID = 1'b1; MEM_AWADDR = 32'h40;
    MEM_WVALID  = 1'b1; MEM_WDATA  = 32'hDEADDEAD; MEM_WSTRB = 4'hF;
    @(negedge clock);
    MEM_AWVALID = 1'b0; MEM_WVALID = 1'b0;
    chk("t6_aw_held", {31'd0, MEM_AWREADY}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_bvalid",  {31'd0, MEM_BVALID},  32'd0);
    chk("t6_rvalid",  {31'd0, MEM_RVALID},  32'd0);
    chk("t6_awready", {31'd0, MEM_AWREADY}, 32'd1);
    chk("t6_wready",  {31'd0, MEM_WREADY},  32'd1);
    chk("t6_arready", {31'd0, MEM_ARREADY}, 32'd1);
    chk("t6_rdata",   MEM_RDATA,            32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    read_word(32'h40, rd);
    chk("t6_target_unchanged", rd, 32'hA5A5A5A5);
    read_word(32'h44, rd);
    chk("t6_prior_commit", rd, 32'h11111111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
